// File: rtl/memory_arbiter_if.sv
// Bundle of requester-side and memory-side signals shared by the arbiter and its environment.
// slave is the arbiter's view; master is the environment's view (requesters plus memory).
interface memory_arbiter_if #(
  parameter int unsigned WIDTH = 16
);
  logic             i_req;
  logic [WIDTH-1:0] i_addr;
  logic [WIDTH-1:0] i_rdata;
  logic             i_done;

  logic             d_req;
  logic             d_we;
  logic [WIDTH-1:0] d_addr;
  logic [WIDTH-1:0] d_wdata;
  logic [WIDTH-1:0] d_rdata;
  logic             d_done;

  logic             readM;
  logic             writeM;
  logic [WIDTH-1:0] address;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             inputReady;
  logic             ackOutput;
  logic             err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, inputReady, ackOutput,
    output i_rdata, i_done, d_rdata, d_done, readM, writeM, address, mem_wdata, err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, inputReady, ackOutput,
    input  i_rdata, i_done, d_rdata, d_done, readM, writeM, address, mem_wdata, err
  );
endinterface

// File: rtl/memory_arbiter.sv
// Two-requester (fetch/data) arbiter onto one memory port with round-robin tie-break
// and a per-access wait-cycle timeout. All outputs are registered.
module memory_arbiter #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  memory_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]       state,      state_n;
  logic [CNT_W-1:0] cnt,        cnt_n;
  logic             last_grant, last_grant_n;  // 1 = data port granted last
  logic             gnt_data,   gnt_data_n;
  logic             pick_data;
  logic             readm_q,    readm_n;
  logic             writem_q,   writem_n;
  logic [WIDTH-1:0] addr_q,     addr_n;
  logic [WIDTH-1:0] wdata_q,    wdata_n;
  logic [WIDTH-1:0] i_rdata_q,  i_rdata_n;
  logic [WIDTH-1:0] d_rdata_q,  d_rdata_n;
  logic             i_done_q,   i_done_n;
  logic             d_done_q,   d_done_n;
  logic             err_q,      err_n;
  logic             expired;

  // Counter hits the limit on this cycle if no response arrives.
  assign expired = (CNT_W'(cnt + CNT_W'(1)) == CNT_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b0;
      gnt_data   <= 1'b0;
      readm_q    <= 1'b0;
      writem_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      i_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      last_grant <= last_grant_n;
      gnt_data   <= gnt_data_n;
      readm_q    <= readm_n;
      writem_q   <= writem_n;
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;
      i_rdata_q  <= i_rdata_n;
      d_rdata_q  <= d_rdata_n;
      i_done_q   <= i_done_n;
      d_done_q   <= d_done_n;
      err_q      <= err_n;
    end
  end

  // Next-state and next-output logic; strobes default low, data registers hold.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    last_grant_n = last_grant;
    gnt_data_n   = gnt_data;
    readm_n      = 1'b0;
    writem_n     = 1'b0;
    addr_n       = addr_q;
    wdata_n      = wdata_q;
    i_rdata_n    = i_rdata_q;
    d_rdata_n    = d_rdata_q;
    i_done_n     = 1'b0;
    d_done_n     = 1'b0;
    err_n        = 1'b0;
    pick_data    = bus.d_req && (!bus.i_req || !last_grant);

    case (state)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          gnt_data_n   = pick_data;
          last_grant_n = pick_data;
          cnt_n        = '0;
          if (pick_data) begin
            addr_n  = bus.d_addr;
            wdata_n = bus.d_wdata;
            if (bus.d_we) begin
              state_n  = WRITE;
              writem_n = 1'b1;
            end else begin
              state_n = READ;
              readm_n = 1'b1;
            end
          end else begin
            addr_n  = bus.i_addr;
            state_n = READ;
            readm_n = 1'b1;
          end
        end
      end
      READ: begin
        if (bus.inputReady) begin
          if (gnt_data) d_rdata_n = bus.mem_rdata;
          else          i_rdata_n = bus.mem_rdata;
          state_n  = RESP;
          d_done_n = gnt_data;
          i_done_n = !gnt_data;
        end else if (expired) begin
          state_n  = RESP;
          d_done_n = gnt_data;
          i_done_n = !gnt_data;
          err_n    = 1'b1;
        end else begin
          cnt_n   = CNT_W'(cnt + CNT_W'(1));
          readm_n = 1'b1;
        end
      end
      WRITE: begin
        if (bus.ackOutput) begin
          state_n  = RESP;
          d_done_n = gnt_data;
          i_done_n = !gnt_data;
        end else if (expired) begin
          state_n  = RESP;
          d_done_n = gnt_data;
          i_done_n = !gnt_data;
          err_n    = 1'b1;
        end else begin
          cnt_n    = CNT_W'(cnt + CNT_W'(1));
          writem_n = 1'b1;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.readM     = readm_q;
  assign bus.writeM    = writem_q;
  assign bus.address   = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_done    = i_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: arbitration, read/write handshakes, timeout,
// spurious responses and reset during an access, with hand-computed expectations.
module tb_memory_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_asserts = 0;
  int   n_fail    = 0;

  memory_arbiter_if #(.WIDTH(16)) bus ();

  memory_arbiter #(.WIDTH(16), .TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.i_req      = 1'b0;
    bus.i_addr     = '0;
    bus.d_req      = 1'b0;
    bus.d_we       = 1'b0;
    bus.d_addr     = '0;
    bus.d_wdata    = '0;
    bus.mem_rdata  = '0;
    bus.inputReady = 1'b0;
    bus.ackOutput  = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_readM",     bus.readM,     0);
    chk("rst_writeM",    bus.writeM,    0);
    chk("rst_address",   bus.address,   0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_i_rdata",   bus.i_rdata,   0);
    chk("rst_d_rdata",   bus.d_rdata,   0);
    chk("rst_i_done",    bus.i_done,    0);
    chk("rst_d_done",    bus.d_done,    0);
    chk("rst_err",       bus.err,       0);

    // Tie right after reset: data first, then fetch
    reset      = 1'b0;
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h0100;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 16'h0020;
    step();
    chk("tie1_readM",   bus.readM,   1);
    chk("tie1_writeM",  bus.writeM,  0);
    chk("tie1_address", bus.address, 16'h0020);
    bus.inputReady = 1'b1;
    bus.mem_rdata  = 16'h1111;
    step();
    chk("tie1_d_done",  bus.d_done,  1);
    chk("tie1_i_done",  bus.i_done,  0);
    chk("tie1_err",     bus.err,     0);
    chk("tie1_d_rdata", bus.d_rdata, 16'h1111);
    chk("tie1_readM_off", bus.readM, 0);
    bus.inputReady = 1'b0;
    bus.d_req      = 1'b0;
    step();
    chk("tie1_d_done_pulse", bus.d_done, 0);
    step();
    chk("tie1_f_readM",   bus.readM,   1);
    chk("tie1_f_address", bus.address, 16'h0100);
    bus.inputReady = 1'b1;
    bus.mem_rdata  = 16'h2222;
    step();
    chk("tie1_f_i_done",  bus.i_done,  1);
    chk("tie1_f_d_done",  bus.d_done,  0);
    chk("tie1_f_i_rdata", bus.i_rdata, 16'h2222);
    chk("tie1_f_d_rdata", bus.d_rdata, 16'h1111);
    bus.inputReady = 1'b0;
    bus.i_req      = 1'b0;
    step();
    chk("tie1_f_i_done_pulse", bus.i_done, 0);
    chk("tie1_f_idle_readM",   bus.readM,  0);

    // Data write, ack in the 4th WRITE cycle (same cycle counter would expire)
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 16'h0040;
    bus.d_wdata = 16'h1234;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("wr_writeM",    bus.writeM,    1);
      chk("wr_readM",     bus.readM,     0);
      chk("wr_mem_wdata", bus.mem_wdata, 16'h1234);
      chk("wr_address",   bus.address,   16'h0040);
      chk("wr_d_done",    bus.d_done,    0);
      if (i == 1) bus.inputReady = 1'b1;
      if (i == 2) bus.inputReady = 1'b0;
      if (i == 3) bus.ackOutput  = 1'b1;
      step();
    end
    chk("wr_done",       bus.d_done, 1);
    chk("wr_err",        bus.err,    0);
    chk("wr_writeM_off", bus.writeM, 0);
    chk("wr_i_done",     bus.i_done, 0);
    bus.ackOutput = 1'b0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    step();
    chk("wr_done_pulse",     bus.d_done,    0);
    chk("wr_hold_mem_wdata", bus.mem_wdata, 16'h1234);
    chk("wr_hold_address",   bus.address,   16'h0040);

    // Repeated tie after a data grant: fetch first, then data
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h0050;
    bus.d_req  = 1'b1;
    bus.d_addr = 16'h0060;
    step();
    chk("tie2_address", bus.address, 16'h0050);
    chk("tie2_readM",   bus.readM,   1);
    bus.inputReady = 1'b1;
    bus.mem_rdata  = 16'h3333;
    step();
    chk("tie2_i_done",  bus.i_done,  1);
    chk("tie2_d_done",  bus.d_done,  0);
    chk("tie2_i_rdata", bus.i_rdata, 16'h3333);
    bus.inputReady = 1'b0;
    bus.i_req      = 1'b0;
    step();
    step();
    chk("tie2_d_address", bus.address, 16'h0060);
    chk("tie2_d_readM",   bus.readM,   1);
    bus.inputReady = 1'b1;
    bus.mem_rdata  = 16'h4444;
    step();
    chk("tie2_d_done2",  bus.d_done,  1);
    chk("tie2_i_done2",  bus.i_done,  0);
    chk("tie2_d_rdata",  bus.d_rdata, 16'h4444);
    bus.inputReady = 1'b0;
    bus.d_req      = 1'b0;
    step();

    // Fetch read with inputReady one cycle after readM rises
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h0010;
    step();
    chk("fr_readM",   bus.readM,   1);
    chk("fr_address", bus.address, 16'h0010);
    step();
    chk("fr_readM2",  bus.readM,   1);
    chk("fr_i_done0", bus.i_done,  0);
    bus.inputReady = 1'b1;
    bus.mem_rdata  = 16'hA5A5;
    step();
    chk("fr_i_rdata", bus.i_rdata, 16'hA5A5);
    chk("fr_i_done",  bus.i_done,  1);
    chk("fr_d_done",  bus.d_done,  0);
    chk("fr_err",     bus.err,     0);
    chk("fr_readM_off", bus.readM, 0);
    bus.inputReady = 1'b0;
    bus.i_req      = 1'b0;
    bus.mem_rdata  = 16'h0000;
    step();
    chk("fr_i_done_pulse", bus.i_done, 0);

    // Timeout: data read with no inputReady (spurious ack ignored)
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 16'h0080;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("to_readM",  bus.readM,  1);
      chk("to_d_done", bus.d_done, 0);
      chk("to_err",    bus.err,    0);
      if (i == 1) bus.ackOutput = 1'b1;
      if (i == 2) bus.ackOutput = 1'b0;
      step();
    end
    chk("to_done",      bus.d_done,  1);
    chk("to_err_pulse", bus.err,     1);
    chk("to_readM_off", bus.readM,   0);
    chk("to_d_rdata",   bus.d_rdata, 16'h4444);
    chk("to_i_done",    bus.i_done,  0);
    bus.d_req = 1'b0;
    step();
    chk("to_err_clear",  bus.err,    0);
    chk("to_done_clear", bus.d_done, 0);

    // Spurious responses in IDLE
    bus.inputReady = 1'b1;
    bus.ackOutput  = 1'b1;
    bus.mem_rdata  = 16'hDEAD;
    step();
    step();
    chk("sp_readM",   bus.readM,   0);
    chk("sp_writeM",  bus.writeM,  0);
    chk("sp_i_done",  bus.i_done,  0);
    chk("sp_d_done",  bus.d_done,  0);
    chk("sp_err",     bus.err,     0);
    chk("sp_i_rdata", bus.i_rdata, 16'hA5A5);
    chk("sp_d_rdata", bus.d_rdata, 16'h4444);
    bus.inputReady = 1'b0;
    bus.ackOutput  = 1'b0;
    step();

    // Reset on the second READ cycle, then a fresh request
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h0030;
    step();
    chk("rm_readM1", bus.readM, 1);
    step();
    chk("rm_readM2", bus.readM, 1);
    reset = 1'b1;
    step();
    chk("rm_readM",     bus.readM,     0);
    chk("rm_writeM",    bus.writeM,    0);
    chk("rm_address",   bus.address,   0);
    chk("rm_mem_wdata", bus.mem_wdata, 0);
    chk("rm_i_rdata",   bus.i_rdata,   0);
    chk("rm_d_rdata",   bus.d_rdata,   0);
    chk("rm_i_done",    bus.i_done,    0);
    chk("rm_d_done",    bus.d_done,    0);
    chk("rm_err",       bus.err,       0);
    reset = 1'b0;
    step();
    chk("rm_fresh_readM",   bus.readM,   1);
    chk("rm_fresh_address", bus.address, 16'h0030);
    bus.inputReady = 1'b1;
    bus.mem_rdata  = 16'h5A5A;
    step();
    chk("rm_fresh_i_done",  bus.i_done,  1);
    chk("rm_fresh_i_rdata", bus.i_rdata, 16'h5A5A);
    chk("rm_fresh_err",     bus.err,     0);
    bus.inputReady = 1'b0;
    bus.i_req      = 1'b0;
    step();
    chk("rm_fresh_i_done_pulse", bus.i_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the address and data width.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, giving the wait-cycle limit per memory access (1..255).
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Ports i_req in 1, i_addr in WIDTH, i_rdata out WIDTH, i_done out 1: instruction-fetch requester (read-only).
REQ-006 Ports d_req in 1, d_we in 1, d_addr in WIDTH, d_wdata in WIDTH, d_rdata out WIDTH, d_done out 1: data requester (d_we=1 write, 0 read).
REQ-007 Ports readM out 1, writeM out 1, address out WIDTH, mem_wdata out WIDTH, mem_rdata in WIDTH: shared memory port; top level drives the bidirectional bus from mem_wdata while writeM=1.
REQ-008 Ports inputReady in 1 (read data valid) and ackOutput in 1 (write accepted): memory responses, sampled synchronously on clk.
REQ-009 Port err out 1: one-cycle pulse marking a timed-out access, aligned with the done pulse.

Function
REQ-010 State machine SHALL use states IDLE, READ, WRITE, RESP.
REQ-011 IDLE: if neither req is high, remain in IDLE; otherwise grant per REQ-012, latch address, wdata and direction, and go to READ or WRITE.
REQ-012 Arbitration: single pending request wins; both pending -> grant the port not recorded in last_grant; last_grant updates on every grant.
REQ-013 Fetch grants are always reads; a data grant goes to WRITE if d_we=1, else READ.
REQ-014 READ: readM=1, address=latched address; on sampled inputReady=1, capture mem_rdata into the granted port's rdata register and go to RESP.
REQ-015 WRITE: writeM=1, address=latched address, mem_wdata=latched wdata; on sampled ackOutput=1 go to RESP.
REQ-016 readM and writeM SHALL be registered, never both 1, and high only in READ and WRITE respectively.
REQ-017 RESP: assert exactly the granted port's done for one cycle, then go to IDLE; requests are not arbitrated in RESP.
REQ-018 A requester holds req, addr, we and wdata stable until its done; it deasserts req in the cycle after done.
REQ-019 Latency: with zero-wait memory (response in the first READ/WRITE cycle), done is high exactly 2 cycles after the cycle in which req is first sampled in IDLE.
REQ-020 i_rdata and d_rdata hold their last captured value until the next successful read on that port.
REQ-021 An 8-bit wait counter clears on entry to READ/WRITE and increments each cycle without a response.
REQ-022 When the counter reaches TIMEOUT: drop readM/writeM, leave rdata unchanged, go to RESP with done and err both high for that cycle.
REQ-023 A response arriving in the same cycle the counter reaches TIMEOUT is accepted as success (err=0).
REQ-024 inputReady in IDLE, WRITE or RESP and ackOutput in IDLE, READ or RESP are ignored.
REQ-025 A request deasserted before its grant is dropped without side effects.
REQ-026 address and mem_wdata hold their latched values outside active states.

Reset
REQ-027 reset=1 at a rising edge: state=IDLE, readM=0, writeM=0, address=0, mem_wdata=0, i_rdata=0, d_rdata=0, i_done=0, d_done=0, err=0, wait counter=0, last_grant=fetch; this makes the data port win the first tie.
REQ-028 Reset during READ/WRITE aborts the access with no done or err pulse; reset has priority over every other event.

Verification
REQ-029 Fetch read: i_req=1, i_addr=0x0010; inputReady one cycle after readM rises, mem_rdata=0xA5A5 -> i_rdata=0xA5A5, one-cycle i_done, d_done=0, err=0.
REQ-030 Tie: i_req and d_req rise together after reset -> data served first, fetch second; repeated tie -> fetch first, then data.
REQ-031 Data write: d_we=1, d_addr=0x0040, d_wdata=0x1234; ackOutput 3 cycles later -> writeM high 4 cycles, mem_wdata=0x1234, d_done pulse, readM stays 0.
REQ-032 Timeout: TIMEOUT=4, read with no inputReady -> readM high 4 cycles, then d_done=1 and err=1 together, d_rdata unchanged.
REQ-033 Reset mid-read: reset=1 on the second READ cycle -> next edge readM=0, no done, all outputs 0; fresh request then completes normally.
REQ-034 Spurious responses: inputReady and ackOutput pulsed in IDLE -> no state change, no done, rdata unchanged.
